// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes and state encodings shared by the LCD string driver.
package lcd_pkg;
    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;
    localparam int WAIT_W = 20;

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_CFG, ST_SNAP, ST_REFRESH, ST_IDLE
    } lcd_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_SETUP, TX_EHI, TX_HOLD, TX_WAIT
    } tx_state_t;
endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: drives one 4-bit LCD write (setup, E pulse, hold) followed by a post-nibble wait.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_E = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rs,
    input  logic [3:0]        nibble,
    input  logic [WAIT_W-1:0] post_wait,
    output logic              done,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic [3:0]        lcd_d
);
    localparam logic [WAIT_W-1:0] E_LAST = WAIT_W'(T_E - 1);

    tx_state_t         state, state_n;
    logic [WAIT_W-1:0] cnt, cnt_n, wait_len, wait_len_n;
    logic              rs_n, e_n;
    logic [3:0]        d_n;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt - 1'b1;
        wait_len_n = wait_len;
        rs_n       = lcd_rs;
        d_n        = lcd_d;
        done       = 1'b0;
        case (state)
            TX_IDLE: begin
                cnt_n = cnt;
                if (start) begin
                    state_n    = TX_SETUP;
                    cnt_n      = WAIT_W'(1);
                    rs_n       = rs;
                    d_n        = nibble;
                    wait_len_n = post_wait - 1'b1;
                end
            end
            TX_SETUP: if (cnt == '0) begin
                state_n = TX_EHI;
                cnt_n   = E_LAST;
            end
            TX_EHI: if (cnt == '0) begin
                state_n = TX_HOLD;
                cnt_n   = WAIT_W'(1);
            end
            TX_HOLD: if (cnt == '0) begin
                state_n = TX_WAIT;
                cnt_n   = wait_len;
            end
            TX_WAIT: if (cnt == '0) begin
                state_n = TX_IDLE;
                cnt_n   = '0;
                done    = 1'b1;
            end
            default: state_n = TX_IDLE;
        endcase
        // E is registered from the next state so it never glitches on a state decode
        e_n = (state_n == TX_EHI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            wait_len <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_d    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wait_len <= wait_len_n;
            lcd_e    <= e_n;
            lcd_rs   <= rs_n;
            lcd_d    <= d_n;
        end
    end
endmodule

// File: rtl/lcd_string_driver.sv
// lcd_string_driver: initialises a 16x2 HD44780 LCD in 4-bit mode and rewrites both lines
// from a 32-character image on power-up and on every refresh request.
module lcd_string_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP      = 750000,
    parameter int unsigned T_INIT_LONG  = 205000,
    parameter int unsigned T_INIT_SHORT = 5000,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLR        = 82000,
    parameter int unsigned T_E          = 12,
    parameter int unsigned T_NIB        = 50
) (
    input  logic         CCLK,
    input  logic         RSTN,
    input  logic [255:0] strdata,
    input  logic         cls,
    output logic         busy,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [3:0]   lcd_d
);
    localparam logic [WAIT_W-1:0] W_PWRUP = WAIT_W'(T_PWRUP - 1);
    localparam logic [WAIT_W-1:0] W_LONG  = WAIT_W'(T_INIT_LONG);
    localparam logic [WAIT_W-1:0] W_SHORT = WAIT_W'(T_INIT_SHORT);
    localparam logic [WAIT_W-1:0] W_CMD   = WAIT_W'(T_CMD);
    localparam logic [WAIT_W-1:0] W_CLR   = WAIT_W'(T_CLR);
    localparam logic [WAIT_W-1:0] W_NIB   = WAIT_W'(T_NIB);

    lcd_state_t        state, state_n;
    logic [WAIT_W-1:0] wcnt, wcnt_n, tx_wait;
    logic [1:0]        step, step_n;
    logic [4:0]        idx, idx_n;
    logic              lo, lo_n, addr, addr_n, issued, issued_n, pending, pending_n, busy_n;
    logic [255:0]      shadow, shadow_n;
    logic [7:0]        pos, char_byte, cfg_byte, cur_byte;
    logic              cur_rs, start, done;
    logic [3:0]        tx_nib;

    assign lcd_rw = 1'b0;

    // Byte/nibble currently being sent, derived from the sequencing position
    always_comb begin
        pos       = 8'd255 - {idx, 3'b000};
        char_byte = shadow[pos -: 8];
        cfg_byte  = step == 2'd0 ? LCD_FUNC_SET : step == 2'd1 ? LCD_ENTRY :
                    step == 2'd2 ? LCD_DISP_ON : LCD_CLEAR;
        cur_rs    = (state == ST_REFRESH) && !addr;
        cur_byte  = state == ST_CFG ? cfg_byte : addr ? (idx[4] ? LCD_LINE2 : LCD_LINE1) : char_byte;
        tx_nib    = state == ST_INIT ? (step == 2'd3 ? 4'h2 : 4'h3) : lo ? cur_byte[3:0] : cur_byte[7:4];
        tx_wait   = state == ST_INIT ? (step == 2'd0 ? W_LONG : step == 2'd3 ? W_CMD : W_SHORT) :
                    !lo ? W_NIB : (!cur_rs && cur_byte == LCD_CLEAR) ? W_CLR : W_CMD;
        start     = (state inside {ST_INIT, ST_CFG, ST_REFRESH}) && !issued;
    end

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        step_n    = step;
        idx_n     = idx;
        lo_n      = lo;
        addr_n    = addr;
        shadow_n  = shadow;
        issued_n  = done ? 1'b0 : start ? 1'b1 : issued;
        pending_n = pending | (cls && state != ST_IDLE);
        case (state)
            ST_PWRUP: begin
                wcnt_n = wcnt == '0 ? '0 : wcnt - 1'b1;
                if (wcnt == '0) begin
                    state_n = ST_INIT;
                    step_n  = 2'd0;
                end
            end
            ST_INIT: if (done) begin
                step_n = step + 2'd1;
                if (step == 2'd3) state_n = ST_CFG;
            end
            ST_CFG: if (done) begin
                lo_n = !lo;
                if (lo) begin
                    step_n = step + 2'd1;
                    if (step == 2'd3) state_n = ST_SNAP;
                end
            end
            ST_SNAP: begin
                shadow_n = strdata;
                addr_n   = 1'b1;
                lo_n     = 1'b0;
                state_n  = ST_REFRESH;
            end
            ST_REFRESH: if (done) begin
                lo_n = !lo;
                if (lo) begin
                    if (addr) begin
                        addr_n = 1'b0;
                    end else begin
                        // idx wraps 31 -> 0 on the way back to IDLE
                        idx_n  = idx + 5'd1;
                        addr_n = idx == 5'd15;
                        if (idx == 5'd31) state_n = ST_IDLE;
                    end
                end
            end
            ST_IDLE: if (cls || pending) begin
                pending_n = 1'b0;
                state_n   = ST_SNAP;
            end
            default: state_n = ST_PWRUP;
        endcase
        busy_n = state_n != ST_IDLE;
    end

    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= ST_PWRUP;
            wcnt    <= W_PWRUP;
            step    <= '0;
            idx     <= '0;
            lo      <= 1'b0;
            addr    <= 1'b0;
            issued  <= 1'b0;
            pending <= 1'b0;
            busy    <= 1'b1;
            shadow  <= '0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            step    <= step_n;
            idx     <= idx_n;
            lo      <= lo_n;
            addr    <= addr_n;
            issued  <= issued_n;
            pending <= pending_n;
            busy    <= busy_n;
            shadow  <= shadow_n;
        end
    end

    lcd_nibble_tx #(.T_E(T_E)) u_tx (
        .clk      (CCLK),
        .rst_n    (RSTN),
        .start    (start),
        .rs       (cur_rs),
        .nibble   (tx_nib),
        .post_wait(tx_wait),
        .done     (done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_d    (lcd_d)
    );
endmodule

// File: tb/tb_lcd_string_driver.sv
// tb_lcd_string_driver: decodes LCD pin activity into nibbles/bytes and compares against a frame model.
module tb_lcd_string_driver;
    localparam int P_PWR = 100;

    logic         CCLK = 1'b0;
    logic         RSTN = 1'b0;
    logic         cls  = 1'b0;
    logic [255:0] strdata;
    logic         busy, lcd_rs, lcd_rw, lcd_e;
    logic [3:0]   lcd_d;

    int passed = 0, total = 0, cyc = 0, first_rise = -1, rw_bad = 0;
    logic prev_e = 1'b0;
    logic [4:0] nq[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_b[34];
    logic [4:0] init_tab[12];
    logic [255:0] exp_imgs[$];

    typedef struct {
        logic [255:0] img;
        logic [7:0]   c0, c15, c16, c31;
    } vec_t;
    vec_t vt[4];

    always #5 CCLK = ~CCLK;

    lcd_string_driver #(
        .T_PWRUP(P_PWR), .T_INIT_LONG(40), .T_INIT_SHORT(20), .T_CMD(10),
        .T_CLR(30), .T_E(2), .T_NIB(3)
    ) dut (
        .CCLK(CCLK), .RSTN(RSTN), .strdata(strdata), .cls(cls), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    // Pin monitor: every rising E latches one {rs, nibble}
    always @(negedge CCLK) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (RSTN) cyc++;
        if (lcd_e && !prev_e) begin
            nq.push_back({lcd_rs, lcd_d});
            if (first_rise < 0) first_rise = cyc;
        end
        prev_e = lcd_e;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CCLK);
        #1;
    endtask

    task automatic pulse_cls;
        cls = 1'b1;
        tick(1);
        cls = 1'b0;
    endtask

    task automatic wait_nibs(input int n, input string nm, output bit ok);
        int k = 0;
        while (nq.size() < n && k < 5000) begin
            tick(1);
            k++;
        end
        ok = nq.size() >= n;
        if (!ok) chk({nm, " nibble timeout"}, 32'(nq.size()), 32'(n));
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 5000) begin
            tick(1);
            k++;
        end
        chk({nm, " busy low"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_quiet(input string nm, input int n);
        tick(n);
        chk({nm, " no extra pulses"}, 32'(nq.size()), 32'd0);
    endtask

    task automatic check_init(input string nm);
        bit ok;
        wait_nibs(12, nm, ok);
        if (ok)
            for (int i = 0; i < 12; i++)
                chk($sformatf("%s init nibble %0d", nm, i), 32'(nq.pop_front()), 32'(init_tab[i]));
    endtask

    // Model: a refresh is line-1 address, chars 0-15, line-2 address, chars 16-31
    task automatic check_frame(input logic [255:0] img, input string nm);
        bit ok;
        int bad = 0, first = 0;
        logic [4:0] hi, lo;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 32; i++) begin
            if (i == 16) exp_q.push_back({1'b0, 8'hC0});
            exp_q.push_back({1'b1, img[255 - 8 * i -: 8]});
        end
        wait_nibs(68, nm, ok);
        if (!ok) return;
        for (int b = 0; b < 34; b++) begin
            hi = nq.pop_front();
            lo = nq.pop_front();
            got_b[b] = {hi[4], hi[3:0], lo[3:0]};
            if (hi[4] !== lo[4] || got_b[b] !== exp_q[b]) begin
                if (bad == 0) first = b;
                bad++;
            end
        end
        total++;
        if (bad == 0) passed++;
        else $display("FAIL %s frame: %0d bad bytes, first at %0d got %h expected %h",
                      nm, bad, first, got_b[first], exp_q[first]);
    endtask

    task automatic rand_img(output logic [255:0] img);
        for (int c = 0; c < 32; c++) img[255 - 8 * c -: 8] = 8'($urandom_range(32, 126));
    endtask

    initial begin
        logic [255:0] img, img2;
        int k;
        bit ok;
        init_tab = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
        vt[0] = '{"01234567 00 00  0123            ", 8'h30, 8'h20, 8'h30, 8'h20};
        vt[1] = '{{32{8'h41}}, 8'h41, 8'h41, 8'h41, 8'h41};
        vt[2] = '{{{16{8'h31}}, {16{8'h7A}}}, 8'h31, 8'h31, 8'h7A, 8'h7A};
        vt[3] = '{{{31{8'h2E}}, 8'h7E}, 8'h2E, 8'h2E, 8'h2E, 8'h7E};

        // Power-up with an all-space image, no cls
        strdata = {32{8'h20}};
        tick(3);
        chk("reset lcd_e", 32'(lcd_e), 32'd0);
        chk("reset lcd_rs", 32'(lcd_rs), 32'd0);
        chk("reset lcd_d", 32'(lcd_d), 32'd0);
        chk("reset busy", 32'(busy), 32'd1);
        @(negedge CCLK);
        RSTN = 1'b1;
        check_init("pwrup");
        chk("first E rise after T_PWRUP", 32'(first_rise >= P_PWR && first_rise <= P_PWR + 20), 32'd1);
        check_frame({32{8'h20}}, "auto refresh");
        wait_idle("auto refresh");
        expect_quiet("auto refresh", 200);

        // Table: image in, decoded frame and key characters out
        for (int i = 0; i < 4; i++) begin
            strdata = vt[i].img;
            pulse_cls();
            chk($sformatf("vec%0d busy after cls", i), 32'(busy), 32'd1);
            check_frame(vt[i].img, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d char0", i), 32'(got_b[1][7:0]), 32'(vt[i].c0));
            chk($sformatf("vec%0d char15", i), 32'(got_b[16][7:0]), 32'(vt[i].c15));
            chk($sformatf("vec%0d char16", i), 32'(got_b[18][7:0]), 32'(vt[i].c16));
            chk($sformatf("vec%0d char31", i), 32'(got_b[33][7:0]), 32'(vt[i].c31));
            wait_idle($sformatf("vec%0d", i));
            expect_quiet($sformatf("vec%0d", i), 50);
        end

        // Two cls during a refresh collapse into one follow-up, which snaps the new image
        strdata = vt[2].img;
        pulse_cls();
        wait_nibs(10, "double cls", ok);
        pulse_cls();
        tick(5);
        pulse_cls();
        strdata = vt[3].img;
        check_frame(vt[2].img, "double cls first");
        check_frame(vt[3].img, "double cls follow-up");
        wait_idle("double cls");
        expect_quiet("double cls", 300);
        pulse_cls();
        check_frame(vt[3].img, "third cls");
        wait_idle("third cls");
        expect_quiet("third cls", 100);

        // strdata change at char 5 must not tear the frame
        strdata = {32{8'h41}};
        pulse_cls();
        wait_nibs(12, "tear", ok);
        strdata = {32{8'h42}};
        check_frame({32{8'h41}}, "no tear A");
        wait_idle("no tear A");
        pulse_cls();
        check_frame({32{8'h42}}, "no tear B");
        wait_idle("no tear B");

        // Random images, optionally with a mid-refresh cls carrying a newer image
        for (int r = 0; r < 5; r++) begin
            rand_img(img);
            tick($urandom_range(1, 20));
            strdata = img;
            pulse_cls();
            exp_imgs.push_back(img);
            if ($urandom_range(0, 1) == 1) begin
                wait_nibs($urandom_range(2, 60), "rand", ok);
                rand_img(img2);
                strdata = img2;
                pulse_cls();
                exp_imgs.push_back(img2);
            end
            while (exp_imgs.size() > 0) check_frame(exp_imgs.pop_front(), $sformatf("rand%0d", r));
            wait_idle($sformatf("rand%0d", r));
            expect_quiet($sformatf("rand%0d", r), 60);
        end

        // Reset while E is high on char 10, then full re-init
        strdata = vt[0].img;
        pulse_cls();
        k = 0;
        while (!(nq.size() >= 23 && lcd_e === 1'b1) && k < 5000) begin
            tick(1);
            k++;
        end
        chk("E high at char 10", 32'(nq.size() >= 23 && lcd_e === 1'b1), 32'd1);
        RSTN = 1'b0;
        #1;
        chk("mid-reset lcd_e drop", 32'(lcd_e), 32'd0);
        chk("mid-reset busy", 32'(busy), 32'd1);
        nq.delete();
        first_rise = -1;
        cyc = 0;
        tick(3);
        @(negedge CCLK);
        RSTN = 1'b1;
        check_init("re-init");
        check_frame(vt[0].img, "re-init refresh");
        wait_idle("re-init");
        chk("lcd_rw stays 0", 32'(rw_bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
